interact_ctrl: RTL and testbench

Sequencing controller for one player move. It accepts a direction request and computes the target tile. It reads that tile from the map RAM, presents the tile to the tile-interaction mux, then commits the results. Committed results are player position, floor, key counts and health registers, plus a map write-back of the replaced tile. It sits between the keyboard/input decoder and the map RAM, and owns the authoritative game-state registers.

---
 rtl/interact_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_interact_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interact_ctrl.sv
// -----------------------------------------------------------------------------
// interact_ctrl
//
// Sequencing controller for a single player move. A direction request is
// turned into a target tile, that tile is read from the map RAM, handed to the
// tile-interaction mux, and the mux results are committed to the game-state
// registers this block owns (floor, position, keys, health). A changed tile is
// written back to the map at the floor the move started on.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   move_valid, move_dir       move request (sampled only while move_ready=1)
//   move_ready                 high only while idle
//   done, blocked              end-of-move pulse; blocked=1 -> position unchanged
//   map_rd_*                   map read strobe/address, map_rd_data one cycle later
//   map_wr_*                   map write strobe/address/tile
//   mt_pos_x/y, mt_tile_id     target position and latched tile to the mux
//   mt_*_out, mt_goto_*, ...   mux results committed at the end of EVAL
//   floor, player_x/y,
//   key_num, health            authoritative game state
// -----------------------------------------------------------------------------
module interact_ctrl #(
    parameter int unsigned MAP_MAX      = 12,
    parameter int unsigned MAX_FLOOR    = 9,
    parameter int unsigned START_X      = 6,
    parameter int unsigned START_Y      = 11,
    parameter int unsigned START_HEALTH = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        move_valid,
    input  logic [1:0]  move_dir,
    output logic        move_ready,
    output logic        done,
    output logic        blocked,
    output logic        map_rd_en,
    output logic [15:0] map_rd_floor,
    output logic [3:0]  map_rd_x,
    output logic [3:0]  map_rd_y,
    input  logic [15:0] map_rd_data,
    output logic        map_wr_en,
    output logic [15:0] map_wr_floor,
    output logic [3:0]  map_wr_x,
    output logic [3:0]  map_wr_y,
    output logic [15:0] map_wr_data,
    output logic [3:0]  mt_pos_x,
    output logic [3:0]  mt_pos_y,
    output logic [15:0] mt_tile_id,
    input  logic [15:0] mt_floor_out,
    input  logic [3:0]  mt_goto_x,
    input  logic [3:0]  mt_goto_y,
    input  logic [31:0] mt_key_num_out,
    input  logic [15:0] mt_health_out,
    input  logic [15:0] mt_new_tile_id,
    output logic [15:0] floor,
    output logic [3:0]  player_x,
    output logic [3:0]  player_y,
    output logic [31:0] key_num,
    output logic [15:0] health
);

    typedef enum logic [2:0] {
        S_IDLE, S_REJECT, S_READ, S_WAIT, S_EVAL, S_WRITE
    } state_t;

    localparam logic [3:0]  MAP_MAX_C   = 4'(MAP_MAX);
    localparam logic [15:0] MAX_FLOOR_C = 16'(MAX_FLOOR);

    state_t      state_q, state_d;
    logic [3:0]  tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
    logic [15:0] src_floor_q, src_floor_d;
    logic [15:0] tile_q, tile_d;
    logic [15:0] new_tile_q, new_tile_d;
    logic [15:0] floor_q, floor_d;
    logic [3:0]  px_q, px_d, py_q, py_d;
    logic [31:0] key_q, key_d;
    logic [15:0] health_q, health_d;
    logic        done_q, done_d;
    logic        blocked_q, blocked_d;
    logic        rd_en_q, rd_en_d;
    logic        wr_en_q, wr_en_d;

    logic [3:0]  nx, ny;
    logic        out_of_range;
    logic        floor_ok;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned; a missing default here would infer a latch.
        state_d      = state_q;
        tgt_x_d      = tgt_x_q;
        tgt_y_d      = tgt_y_q;
        src_floor_d  = src_floor_q;
        tile_d       = tile_q;
        new_tile_d   = new_tile_q;
        floor_d      = floor_q;
        px_d         = px_q;
        py_d         = py_q;
        key_d        = key_q;
        health_d     = health_q;
        done_d       = 1'b0;
        blocked_d    = 1'b0;
        rd_en_d      = 1'b0;
        wr_en_d      = 1'b0;
        nx           = px_q;
        ny           = py_q;
        out_of_range = 1'b0;
        floor_ok     = (mt_floor_out <= MAX_FLOOR_C);

        // Target candidate and edge-of-map check for the requested direction.
        unique case (move_dir)
            2'd0: begin out_of_range = (py_q == 4'd0);       ny = py_q - 4'd1; end
            2'd1: begin out_of_range = (py_q >= MAP_MAX_C);  ny = py_q + 4'd1; end
            2'd2: begin out_of_range = (px_q == 4'd0);       nx = px_q - 4'd1; end
            default: begin out_of_range = (px_q >= MAP_MAX_C); nx = px_q + 4'd1; end
        endcase

        // Strobes, done and blocked are registered: they are computed for the
        // state being entered so they line up with that state's cycle.
        unique case (state_q)
            S_IDLE: begin
                if (move_valid) begin
                    if (out_of_range) begin
                        state_d   = S_REJECT;
                        done_d    = 1'b1;
                        blocked_d = 1'b1;
                    end else begin
                        state_d     = S_READ;
                        tgt_x_d     = nx;
                        tgt_y_d     = ny;
                        src_floor_d = floor_q;
                        rd_en_d     = 1'b1;
                    end
                end
            end
            S_REJECT: state_d = S_IDLE;
            S_READ:   state_d = S_WAIT;
            S_WAIT: begin
                tile_d  = map_rd_data;
                state_d = S_EVAL;
            end
            S_EVAL: begin
                // Keys and health commit even when the floor result is invalid.
                key_d      = mt_key_num_out;
                health_d   = mt_health_out;
                new_tile_d = mt_new_tile_id;
                if (floor_ok) begin
                    floor_d   = mt_floor_out;
                    px_d      = mt_goto_x;
                    py_d      = mt_goto_y;
                    blocked_d = (mt_goto_x == px_q) && (mt_goto_y == py_q) &&
                                (mt_floor_out == floor_q);
                    wr_en_d   = (mt_new_tile_id != tile_q);
                end else begin
                    blocked_d = 1'b1;
                end
                done_d  = 1'b1;
                state_d = S_WRITE;
            end
            S_WRITE:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tgt_x_q     <= '0;
            tgt_y_q     <= '0;
            src_floor_q <= '0;
            tile_q      <= '0;
            new_tile_q  <= '0;
            floor_q     <= '0;
            px_q        <= 4'(START_X);
            py_q        <= 4'(START_Y);
            key_q       <= '0;
            health_q    <= 16'(START_HEALTH);
            done_q      <= 1'b0;
            blocked_q   <= 1'b0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tgt_x_q     <= tgt_x_d;
            tgt_y_q     <= tgt_y_d;
            src_floor_q <= src_floor_d;
            tile_q      <= tile_d;
            new_tile_q  <= new_tile_d;
            floor_q     <= floor_d;
            px_q        <= px_d;
            py_q        <= py_d;
            key_q       <= key_d;
            health_q    <= health_d;
            done_q      <= done_d;
            blocked_q   <= blocked_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
        end
    end

    assign move_ready   = (state_q == S_IDLE);
    assign done         = done_q;
    assign blocked      = blocked_q;
    assign map_rd_en    = rd_en_q;
    assign map_rd_floor = src_floor_q;
    assign map_rd_x     = tgt_x_q;
    assign map_rd_y     = tgt_y_q;
    // Write-back always targets the floor the move started on.
    assign map_wr_en    = wr_en_q;
    assign map_wr_floor = src_floor_q;
    assign map_wr_x     = tgt_x_q;
    assign map_wr_y     = tgt_y_q;
    assign map_wr_data  = new_tile_q;
    assign mt_pos_x     = tgt_x_q;
    assign mt_pos_y     = tgt_y_q;
    assign mt_tile_id   = tile_q;
    assign floor        = floor_q;
    assign player_x     = px_q;
    assign player_y     = py_q;
    assign key_num      = key_q;
    assign health       = health_q;

endmodule

// File: tb/tb_interact_ctrl.sv
// -----------------------------------------------------------------------------
// tb_interact_ctrl
//
// Directed bench for interact_ctrl. The bench plays both the map RAM (returns
// the vector's tile in the cycle after the read strobe) and the interaction
// mux (drives the vector's results). A table of moves is applied in order; each
// row carries the hand-computed strobes, addresses and resulting game state.
// -----------------------------------------------------------------------------
module tb_interact_ctrl;

    logic        clk;
    logic        rst_n;
    logic        move_valid;
    logic [1:0]  move_dir;
    logic        move_ready;
    logic        done;
    logic        blocked;
    logic        map_rd_en;
    logic [15:0] map_rd_floor;
    logic [3:0]  map_rd_x;
    logic [3:0]  map_rd_y;
    logic [15:0] map_rd_data;
    logic        map_wr_en;
    logic [15:0] map_wr_floor;
    logic [3:0]  map_wr_x;
    logic [3:0]  map_wr_y;
    logic [15:0] map_wr_data;
    logic [3:0]  mt_pos_x;
    logic [3:0]  mt_pos_y;
    logic [15:0] mt_tile_id;
    logic [15:0] mt_floor_out;
    logic [3:0]  mt_goto_x;
    logic [3:0]  mt_goto_y;
    logic [31:0] mt_key_num_out;
    logic [15:0] mt_health_out;
    logic [15:0] mt_new_tile_id;
    logic [15:0] floor;
    logic [3:0]  player_x;
    logic [3:0]  player_y;
    logic [31:0] key_num;
    logic [15:0] health;

    interact_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .move_valid(move_valid), .move_dir(move_dir), .move_ready(move_ready),
        .done(done), .blocked(blocked),
        .map_rd_en(map_rd_en), .map_rd_floor(map_rd_floor),
        .map_rd_x(map_rd_x), .map_rd_y(map_rd_y), .map_rd_data(map_rd_data),
        .map_wr_en(map_wr_en), .map_wr_floor(map_wr_floor),
        .map_wr_x(map_wr_x), .map_wr_y(map_wr_y), .map_wr_data(map_wr_data),
        .mt_pos_x(mt_pos_x), .mt_pos_y(mt_pos_y), .mt_tile_id(mt_tile_id),
        .mt_floor_out(mt_floor_out), .mt_goto_x(mt_goto_x), .mt_goto_y(mt_goto_y),
        .mt_key_num_out(mt_key_num_out), .mt_health_out(mt_health_out),
        .mt_new_tile_id(mt_new_tile_id),
        .floor(floor), .player_x(player_x), .player_y(player_y),
        .key_num(key_num), .health(health)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  dir;
        logic        rej;
        logic [15:0] f;     // expected read/write floor
        logic [3:0]  tx;    // expected target
        logic [3:0]  ty;
        logic [15:0] tile;  // RAM contents at target
        logic [15:0] mf;    // mux results
        logic [3:0]  gx;
        logic [3:0]  gy;
        logic [31:0] k;
        logic [15:0] h;
        logic [15:0] nt;
        logic        bl;    // expected blocked
        logic        wr;    // expected write-back
        logic [15:0] ef;    // expected state after the move
        logic [3:0]  ex;
        logic [3:0]  ey;
        logic [31:0] ek;
        logic [15:0] eh;
    } vec_t;

    int n_total = 0;
    int n_bad   = 0;
    vec_t vecs[19];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(
        input logic [1:0] dir, input logic rej,
        input logic [15:0] f, input logic [3:0] tx, input logic [3:0] ty,
        input logic [15:0] tile, input logic [15:0] mf,
        input logic [3:0] gx, input logic [3:0] gy,
        input logic [31:0] k, input logic [15:0] h, input logic [15:0] nt,
        input logic bl, input logic wr,
        input logic [15:0] ef, input logic [3:0] ex, input logic [3:0] ey,
        input logic [31:0] ek, input logic [15:0] eh);
        vec_t v;
        v.dir = dir; v.rej = rej; v.f = f; v.tx = tx; v.ty = ty; v.tile = tile;
        v.mf = mf; v.gx = gx; v.gy = gy; v.k = k; v.h = h; v.nt = nt;
        v.bl = bl; v.wr = wr; v.ef = ef; v.ex = ex; v.ey = ey; v.ek = ek; v.eh = eh;
        return v;
    endfunction

    task automatic check_state(input string p, input logic [15:0] ef, input logic [3:0] ex,
                               input logic [3:0] ey, input logic [31:0] ek, input logic [15:0] eh);
        check({p, " floor"},    64'(floor),    64'(ef));
        check({p, " player_x"}, 64'(player_x), 64'(ex));
        check({p, " player_y"}, 64'(player_y), 64'(ey));
        check({p, " key_num"},  64'(key_num),  64'(ek));
        check({p, " health"},   64'(health),   64'(eh));
    endtask

    // One complete move. move_valid is left high with a different direction
    // while the controller is busy; a queued request would show up as an
    // unexpected read or a dropped move_ready in the cycle after the move.
    task automatic run_move(input string p, input vec_t v);
        mt_floor_out   = v.mf;
        mt_goto_x      = v.gx;
        mt_goto_y      = v.gy;
        mt_key_num_out = v.k;
        mt_health_out  = v.h;
        mt_new_tile_id = v.nt;
        check({p, " T ready"}, 64'(move_ready), 64'd1);
        move_valid = 1'b1;
        move_dir   = v.dir;
        step();                                         // T+1
        move_dir = ~v.dir;
        check({p, " T+1 ready"}, 64'(move_ready), 64'd0);
        check({p, " T+1 wr_en"}, 64'(map_wr_en), 64'd0);
        if (v.rej) begin
            check({p, " T+1 rd_en"},   64'(map_rd_en), 64'd0);
            check({p, " T+1 done"},    64'(done),      64'd1);
            check({p, " T+1 blocked"}, 64'(blocked),   64'd1);
            step();                                     // T+2
            move_valid = 1'b0;
            check({p, " T+2 ready"}, 64'(move_ready), 64'd1);
            check({p, " T+2 done"},  64'(done),       64'd0);
            check({p, " T+2 rd_en"}, 64'(map_rd_en),  64'd0);
        end else begin
            check({p, " T+1 rd_en"}, 64'(map_rd_en),    64'd1);
            check({p, " T+1 done"},  64'(done),         64'd0);
            check({p, " rd_floor"},  64'(map_rd_floor), 64'(v.f));
            check({p, " rd_x"},      64'(map_rd_x),     64'(v.tx));
            check({p, " rd_y"},      64'(map_rd_y),     64'(v.ty));
            step();                                     // T+2: read data returned
            map_rd_data = v.tile;
            check({p, " T+2 rd_en"}, 64'(map_rd_en), 64'd0);
            check({p, " T+2 done"},  64'(done),      64'd0);
            check({p, " T+2 wr_en"}, 64'(map_wr_en), 64'd0);
            step();                                     // T+3: EVAL
            map_rd_data = 16'hDEAD;
            check({p, " mt_tile_id"}, 64'(mt_tile_id), 64'(v.tile));
            check({p, " mt_pos_x"},   64'(mt_pos_x),   64'(v.tx));
            check({p, " mt_pos_y"},   64'(mt_pos_y),   64'(v.ty));
            check({p, " T+3 rd_en"},  64'(map_rd_en),  64'd0);
            check({p, " T+3 wr_en"},  64'(map_wr_en),  64'd0);
            check({p, " T+3 done"},   64'(done),       64'd0);
            step();                                     // T+4: WRITE
            check({p, " T+4 done"},    64'(done),      64'd1);
            check({p, " T+4 blocked"}, 64'(blocked),   64'(v.bl));
            check({p, " T+4 wr_en"},   64'(map_wr_en), 64'(v.wr));
            check({p, " T+4 rd_en"},   64'(map_rd_en), 64'd0);
            check({p, " T+4 ready"},   64'(move_ready), 64'd0);
            if (v.wr) begin
                check({p, " wr_floor"}, 64'(map_wr_floor), 64'(v.f));
                check({p, " wr_x"},     64'(map_wr_x),     64'(v.tx));
                check({p, " wr_y"},     64'(map_wr_y),     64'(v.ty));
                check({p, " wr_data"},  64'(map_wr_data),  64'(v.nt));
            end
            step();                                     // T+5
            move_valid = 1'b0;
            check({p, " T+5 ready"}, 64'(move_ready), 64'd1);
            check({p, " T+5 done"},  64'(done),       64'd0);
            check({p, " T+5 wr_en"}, 64'(map_wr_en),  64'd0);
            check({p, " T+5 rd_en"}, 64'(map_rd_en),  64'd0);
        end
        check_state(p, v.ef, v.ex, v.ey, v.ek, v.eh);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t r;
        rst_n          = 1'b0;
        move_valid     = 1'b0;
        move_dir       = 2'd0;
        map_rd_data    = 16'hDEAD;
        mt_floor_out   = '0;
        mt_goto_x      = '0;
        mt_goto_y      = '0;
        mt_key_num_out = '0;
        mt_health_out  = '0;
        mt_new_tile_id = '0;

        //            dir rej  f  tx ty  tile     mf      gx gy  k              h     nt       bl wr  ef  ex ey  ek            eh
        vecs[0]  = mk(0, 0,  0, 6, 10, 16'h0000, 16'd0,   6, 10, 32'd0,        16'd100, 16'h0000, 0, 0, 0, 6, 10, 32'd0,        16'd100);
        vecs[1]  = mk(0, 0,  0, 6, 9,  16'h0005, 16'd0,   6, 9,  32'd1,        16'd100, 16'h0000, 0, 1, 0, 6, 9,  32'd1,        16'd100);
        vecs[2]  = mk(3, 0,  0, 7, 9,  16'h0002, 16'd0,   6, 9,  32'd1,        16'd100, 16'h0002, 1, 0, 0, 6, 9,  32'd1,        16'd100);
        vecs[3]  = mk(2, 0,  0, 5, 9,  16'h0010, 16'd0,   5, 9,  32'd1,        16'd60,  16'h0000, 0, 1, 0, 5, 9,  32'd1,        16'd60);
        vecs[4]  = mk(1, 0,  0, 5, 10, 16'h0020, 16'hFFFF, 3, 3, 32'd7,        16'd50,  16'h0000, 1, 0, 0, 5, 9,  32'd7,        16'd50);
        vecs[5]  = mk(0, 0,  0, 5, 8,  16'h0021, 16'd3,   2, 2,  32'd7,        16'd50,  16'h0021, 0, 0, 3, 2, 2,  32'd7,        16'd50);
        vecs[6]  = mk(3, 0,  3, 3, 2,  16'h0021, 16'd4,   3, 2,  32'd7,        16'd50,  16'h0000, 0, 1, 4, 3, 2,  32'd7,        16'd50);
        vecs[7]  = mk(0, 0,  4, 3, 1,  16'h0022, 16'd5,   3, 2,  32'd7,        16'd50,  16'h0022, 0, 0, 5, 3, 2,  32'd7,        16'd50);
        vecs[8]  = mk(2, 0,  5, 2, 2,  16'h0021, 16'd9,   2, 2,  32'd7,        16'd50,  16'h0000, 0, 1, 9, 2, 2,  32'd7,        16'd50);
        vecs[9]  = mk(2, 0,  9, 1, 2,  16'h0021, 16'd10,  1, 2,  32'd8,        16'd40,  16'h0000, 1, 0, 9, 2, 2,  32'd8,        16'd40);
        vecs[10] = mk(2, 0,  9, 1, 2,  16'h0000, 16'd9,   1, 2,  32'd8,        16'd40,  16'h0000, 0, 0, 9, 1, 2,  32'd8,        16'd40);
        vecs[11] = mk(2, 0,  9, 0, 2,  16'h0000, 16'd9,   0, 2,  32'd8,        16'd40,  16'h0000, 0, 0, 9, 0, 2,  32'd8,        16'd40);
        vecs[12] = mk(2, 1,  0, 0, 0,  16'h0000, 16'd0,   0, 0,  32'd0,        16'd0,   16'h0000, 1, 0, 9, 0, 2,  32'd8,        16'd40);
        vecs[13] = mk(0, 0,  9, 0, 1,  16'h0000, 16'd9,   0, 0,  32'd8,        16'd40,  16'h0000, 0, 0, 9, 0, 0,  32'd8,        16'd40);
        vecs[14] = mk(0, 1,  0, 0, 0,  16'h0000, 16'd0,   0, 0,  32'd0,        16'd0,   16'h0000, 1, 0, 9, 0, 0,  32'd8,        16'd40);
        vecs[15] = mk(1, 0,  9, 0, 1,  16'h0030, 16'd9,   12, 12, 32'hFFFFFFFF, 16'd0,  16'h0031, 0, 1, 9, 12, 12, 32'hFFFFFFFF, 16'd0);
        vecs[16] = mk(3, 1,  0, 0, 0,  16'h0000, 16'd0,   0, 0,  32'd0,        16'd0,   16'h0000, 1, 0, 9, 12, 12, 32'hFFFFFFFF, 16'd0);
        vecs[17] = mk(1, 1,  0, 0, 0,  16'h0000, 16'd0,   0, 0,  32'd0,        16'd0,   16'h0000, 1, 0, 9, 12, 12, 32'hFFFFFFFF, 16'd0);
        vecs[18] = mk(0, 0,  9, 12, 11, 16'h0000, 16'd9,  12, 11, 32'hFFFFFFFF, 16'd0,  16'h0000, 0, 0, 9, 12, 11, 32'hFFFFFFFF, 16'd0);

        // Reset state, checked both while held and after release.
        step();
        step();
        check_state("in_reset", 16'd0, 4'd6, 4'd11, 32'd0, 16'd100);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("reset ready",   64'(move_ready), 64'd1);
        check("reset done",    64'(done),       64'd0);
        check("reset blocked", 64'(blocked),    64'd0);
        check("reset rd_en",   64'(map_rd_en),  64'd0);
        check("reset wr_en",   64'(map_wr_en),  64'd0);
        check("reset mt_pos",  64'({mt_pos_x, mt_pos_y}), 64'd0);
        check("reset tile",    64'(mt_tile_id), 64'd0);
        check_state("reset", 16'd0, 4'd6, 4'd11, 32'd0, 16'd100);

        for (int i = 0; i < 19; i++) begin
            run_move($sformatf("v%0d", i), vecs[i]);
        end

        // Reset asserted while the move sits in WAIT: the move is abandoned
        // and no write-back may follow.
        mt_floor_out   = 16'd9;
        mt_goto_x      = 4'd12;
        mt_goto_y      = 4'd10;
        mt_key_num_out = 32'd3;
        mt_health_out  = 16'd20;
        mt_new_tile_id = 16'h0000;
        move_valid = 1'b1;
        move_dir   = 2'd0;
        step();                                         // READ
        move_valid = 1'b0;
        check("abort rd_en", 64'(map_rd_en), 64'd1);
        step();                                         // WAIT
        map_rd_data = 16'h0040;
        rst_n = 1'b0;
        #1;
        check("abort ready",  64'(move_ready), 64'd1);
        check("abort rd_en0", 64'(map_rd_en),  64'd0);
        check("abort mt_pos", 64'({mt_pos_x, mt_pos_y}), 64'd0);
        check_state("abort", 16'd0, 4'd6, 4'd11, 32'd0, 16'd100);
        step();
        step();
        map_rd_data = 16'hDEAD;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            check($sformatf("post_abort c%0d wr_en", c), 64'(map_wr_en), 64'd0);
            check($sformatf("post_abort c%0d done", c),  64'(done),      64'd0);
        end
        r = mk(0, 0, 0, 6, 10, 16'h0005, 16'd0, 6, 10, 32'd1, 16'd100, 16'h0000, 0, 1,
               0, 6, 10, 32'd1, 16'd100);
        run_move("after_abort", r);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
